// File: rtl/pacman_motion.sv
`default_nettype none
// pacman_motion: Pac-Man position, facing, mouth animation and death/respawn control.
// Define PACMAN_TUNNEL_WRAP_EN to make x wrap between X_MIN and X_MAX instead of clamping.
module pacman_motion #(
  parameter logic [8:0]  START_X        = 9'd112,
  parameter logic [8:0]  START_Y        = 9'd188,
  parameter logic [8:0]  X_MIN          = 9'd7,
  parameter logic [8:0]  X_MAX          = 9'd216,
  parameter logic [2:0]  TILE_CENTER    = 3'd4,
  parameter int unsigned SPEED_DIV      = 2,
  parameter int unsigned ANIM_DIV       = 4,
  parameter int unsigned RESPAWN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] dir_req,
  input  logic       dir_req_valid,
  input  logic [3:0] blocked,
  input  logic       kill,
  output logic [8:0] xloc,
  output logic [8:0] yloc,
  output logic [1:0] pacman_dir,
  output logic       pacman_alive,
  output logic [1:0] animation_cycle,
  output logic       moving
);

  localparam logic [3:0] SPEED_LAST   = 4'(SPEED_DIV - 1);
  localparam logic [3:0] ANIM_LAST    = 4'(ANIM_DIV - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DEAD = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [8:0] x_nxt, y_nxt;
  logic [1:0] dir_nxt, anim_nxt, pend_dir, pend_dir_nxt;
  logic       alive_nxt, moving_nxt, pend_valid, pend_valid_nxt;
  logic [3:0] frame_cnt, frame_cnt_nxt, anim_cnt, anim_cnt_nxt;
  logic [7:0] death_cnt, death_cnt_nxt, death_inc;

  logic       at_center, take_pend, step_ok;
  logic [1:0] step_dir;
  logic [8:0] step_x, step_y;

  assign death_inc = death_cnt + 8'd1;

  // Candidate move for the next step tick: direction after any turn, target position, success.
  always_comb begin
    at_center = (xloc[2:0] == TILE_CENTER) && (yloc[2:0] == TILE_CENTER);
    take_pend = pend_valid &&
                ((pend_dir == ~pacman_dir) || (at_center && !blocked[pend_dir]));
    step_dir  = take_pend ? pend_dir : pacman_dir;
    step_ok   = !(at_center && blocked[step_dir]);
    step_x    = xloc;
    step_y    = yloc;
    case (step_dir)
      2'b00: begin
        if (xloc >= X_MAX) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          step_x = X_MIN;
`else
          step_ok = 1'b0;
`endif
        end else begin
          step_x = xloc + 9'd1;
        end
      end
      2'b01: step_y = yloc - 9'd1;
      2'b10: step_y = yloc + 9'd1;
      default: begin
        if (xloc <= X_MIN) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
          step_x = X_MAX;
`else
          step_ok = 1'b0;
`endif
        end else begin
          step_x = xloc - 9'd1;
        end
      end
    endcase
  end

  always_comb begin
    state_nxt      = state;
    x_nxt          = xloc;
    y_nxt          = yloc;
    dir_nxt        = pacman_dir;
    alive_nxt      = pacman_alive;
    anim_nxt       = animation_cycle;
    moving_nxt     = moving;
    pend_dir_nxt   = pend_dir;
    pend_valid_nxt = pend_valid;
    frame_cnt_nxt  = frame_cnt;
    anim_cnt_nxt   = anim_cnt;
    death_cnt_nxt  = death_cnt;
    case (state)
      RUN: begin
        if (kill) begin
          state_nxt     = DEAD;
          alive_nxt     = 1'b0;
          moving_nxt    = 1'b0;
          anim_nxt      = 2'd0;
          anim_cnt_nxt  = 4'd0;
          death_cnt_nxt = 8'd0;
        end else begin
          if (frame_tick) begin
            if (frame_cnt == SPEED_LAST) begin
              frame_cnt_nxt = 4'd0;
              dir_nxt       = step_dir;
              moving_nxt    = step_ok;
              if (take_pend) begin
                pend_valid_nxt = 1'b0;
              end
              if (step_ok) begin
                x_nxt = step_x;
                y_nxt = step_y;
                if (anim_cnt == ANIM_LAST) begin
                  anim_cnt_nxt = 4'd0;
                  anim_nxt     = animation_cycle + 2'd1;
                end else begin
                  anim_cnt_nxt = anim_cnt + 4'd1;
                end
              end
            end else begin
              frame_cnt_nxt = frame_cnt + 4'd1;
            end
          end
          // A request arriving on a step edge is kept for a later tick, overriding any older one.
          if (dir_req_valid) begin
            pend_dir_nxt   = dir_req;
            pend_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (frame_tick) begin
          death_cnt_nxt = death_inc;
          if (death_inc == RESPAWN_LAST) begin
            state_nxt      = RUN;
            x_nxt          = START_X;
            y_nxt          = START_Y;
            dir_nxt        = 2'b00;
            alive_nxt      = 1'b1;
            pend_valid_nxt = 1'b0;
            frame_cnt_nxt  = 4'd0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      xloc            <= START_X;
      yloc            <= START_Y;
      pacman_dir      <= 2'b00;
      pacman_alive    <= 1'b1;
      animation_cycle <= 2'd0;
      moving          <= 1'b0;
      pend_dir        <= 2'b00;
      pend_valid      <= 1'b0;
      frame_cnt       <= 4'd0;
      anim_cnt        <= 4'd0;
      death_cnt       <= 8'd0;
    end else begin
      state           <= state_nxt;
      xloc            <= x_nxt;
      yloc            <= y_nxt;
      pacman_dir      <= dir_nxt;
      pacman_alive    <= alive_nxt;
      animation_cycle <= anim_nxt;
      moving          <= moving_nxt;
      pend_dir        <= pend_dir_nxt;
      pend_valid      <= pend_valid_nxt;
      frame_cnt       <= frame_cnt_nxt;
      anim_cnt        <= anim_cnt_nxt;
      death_cnt       <= death_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pacman_motion.sv
`default_nettype none
// tb_pacman_motion: directed and random stimulus against a behavioural model; a monitor
// process compares every post-edge output set against the expectation queue.
module tb_pacman_motion;

  localparam int SPEED_DIV = 2;
  localparam int ANIM_DIV  = 4;
  localparam int RESPAWN   = 120;
  localparam int X_MIN     = 7;
  localparam int X_MAX     = 216;
  localparam int START_X   = 112;
  localparam int START_Y   = 188;
  localparam int TC        = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] dir_req = 2'b00;
  logic       dir_req_valid = 1'b0;
  logic [3:0] blocked = 4'b0000;
  logic       kill = 1'b0;
  logic [8:0] xloc, yloc;
  logic [1:0] pacman_dir, animation_cycle;
  logic       pacman_alive, moving;

  pacman_motion dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .dir_req        (dir_req),
    .dir_req_valid  (dir_req_valid),
    .blocked        (blocked),
    .kill           (kill),
    .xloc           (xloc),
    .yloc           (yloc),
    .pacman_dir     (pacman_dir),
    .pacman_alive   (pacman_alive),
    .animation_cycle(animation_cycle),
    .moving         (moving)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  // Behavioural model state
  int m_x, m_y, m_dir, m_alive, m_anim, m_moving, m_pv, m_pd, m_fc, m_ac, m_dc;
  bit m_dead;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pack_exp();
    return {9'(m_x), 9'(m_y), 2'(m_dir), 1'(m_alive), 2'(m_anim), 1'(m_moving)};
  endfunction

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_dir = 0; m_alive = 1; m_anim = 0; m_moving = 0;
    m_pv = 0; m_pd = 0; m_fc = 0; m_ac = 0; m_dc = 0; m_dead = 0;
  endtask

  task automatic model_move(input logic [3:0] blk);
    bit center, ok;
    int dx, dy, nx;
    center = ((m_x % 8) == TC) && ((m_y % 8) == TC);
    if (m_pv == 1) begin
      if ((m_pd + m_dir) == 3 || (center && blk[m_pd] == 1'b0)) begin
        m_dir = m_pd;
        m_pv  = 0;
      end
    end
    ok = !(center && blk[m_dir] == 1'b1);
    dx = (m_dir == 0) ? 1 : (m_dir == 3) ? -1 : 0;
    dy = (m_dir == 2) ? 1 : (m_dir == 1) ? -1 : 0;
    nx = m_x + dx;
    if (nx < X_MIN || nx > X_MAX) begin
`ifdef PACMAN_TUNNEL_WRAP_EN
      nx = (nx < X_MIN) ? X_MAX : X_MIN;
`else
      ok = 0;
`endif
    end
    m_moving = ok ? 1 : 0;
    if (ok) begin
      m_x = nx;
      m_y = (m_y + dy + 512) % 512;
      m_ac++;
      if (m_ac == ANIM_DIV) begin
        m_ac   = 0;
        m_anim = (m_anim + 1) % 4;
      end
    end
  endtask

  task automatic model_step(input bit r, input bit ft, input bit drv, input bit k,
                            input logic [1:0] dr, input logic [3:0] blk);
    if (r) begin
      model_reset();
    end else if (!m_dead) begin
      if (k) begin
        m_dead = 1; m_alive = 0; m_moving = 0; m_anim = 0; m_ac = 0; m_dc = 0;
      end else begin
        if (ft) begin
          m_fc++;
          if (m_fc == SPEED_DIV) begin
            m_fc = 0;
            model_move(blk);
          end
        end
        if (drv) begin
          m_pv = 1;
          m_pd = int'(dr);
        end
      end
    end else if (ft) begin
      m_dc++;
      if (m_dc == RESPAWN) begin
        m_dead = 0; m_alive = 1; m_x = START_X; m_y = START_Y; m_dir = 0;
        m_pv = 0; m_fc = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit ft, input bit drv, input bit k,
                       input logic [1:0] dr, input logic [3:0] blk);
    @(negedge clk);
    rst = r; frame_tick = ft; dir_req_valid = drv; kill = k; dir_req = dr; blocked = blk;
    model_step(r, ft, drv, k, dr, blk);
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [1:0] dr);
    cycle(0, 0, 1, 0, dr, 4'b0000);
  endtask

  task automatic step(input logic [3:0] blk);
    cycle(0, 1, 0, 0, 2'b00, blk);
    cycle(0, 0, 0, 0, 2'b00, blk);
    cycle(0, 1, 0, 0, 2'b00, blk);
  endtask

  always @(posedge clk) begin : monitor
    logic [23:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs{x,y,dir,alive,anim,moving}",
          {8'd0, xloc, yloc, pacman_dir, pacman_alive, animation_cycle, moving}, {8'd0, e});
    end
  end

  initial begin
    logic [3:0] blk;
    model_reset();
    cycle(1, 0, 0, 0, 2'b00, 4'b0000);
    cycle(1, 1, 1, 1, 2'b11, 4'b1111);
    chk("reset_x", 32'(xloc), 112);
    chk("reset_y", 32'(yloc), 188);
    chk("reset_dir", 32'(pacman_dir), 0);
    chk("reset_alive", 32'(pacman_alive), 1);
    chk("reset_anim", 32'(animation_cycle), 0);
    chk("reset_moving", 32'(moving), 0);

    step(4'b0000);
    chk("first_step_x", 32'(xloc), 113);
    chk("first_step_moving", 32'(moving), 1);

    req(2'b11);
    step(4'b0000);
    chk("reverse_dir", 32'(pacman_dir), 3);
    chk("reverse_x", 32'(xloc), 112);
    req(2'b00);
    step(4'b0000);

    repeat (3) step(4'b0001);
    chk("reach_center_x", 32'(xloc), 116);
    step(4'b0001);
    chk("blocked_x", 32'(xloc), 116);
    chk("blocked_moving", 32'(moving), 0);
    step(4'b0001);
    chk("blocked_anim_frozen", 32'(animation_cycle), 1);

    req(2'b01);
    step(4'b0001);
    chk("turn_up_dir", 32'(pacman_dir), 1);
    chk("turn_up_y", 32'(yloc), 187);
    step(4'b0001);
    chk("up_y", 32'(yloc), 186);

    cycle(0, 1, 0, 1, 2'b00, 4'b0000);
    chk("kill_alive", 32'(pacman_alive), 0);
    chk("kill_x", 32'(xloc), 116);
    repeat (119) begin
      cycle(0, 1, 1, 1, 2'b10, 4'b0000);
      cycle(0, 0, 0, 0, 2'b00, 4'b0000);
    end
    chk("still_dead", 32'(pacman_alive), 0);
    cycle(0, 1, 0, 0, 2'b00, 4'b0000);
    chk("respawn_alive", 32'(pacman_alive), 1);
    chk("respawn_x", 32'(xloc), 112);
    chk("respawn_y", 32'(yloc), 188);

    req(2'b11);
    step(4'b0000);
    repeat (104) step(4'b0000);
    chk("left_edge_x", 32'(xloc), 7);
    step(4'b0000);
`ifdef PACMAN_TUNNEL_WRAP_EN
    chk("edge_x", 32'(xloc), 216);
    chk("edge_moving", 32'(moving), 1);
`else
    chk("edge_x", 32'(xloc), 7);
    chk("edge_moving", 32'(moving), 0);
`endif

    cycle(1, 0, 0, 0, 2'b00, 4'b0000);
    for (int i = 0; i < 15000; i++) begin
      blk = 4'($urandom) & 4'($urandom);
      cycle(($urandom_range(0, 2999) == 0), 1'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 399) == 0), 2'($urandom), blk);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pacman_motion.md
PACMAN_MOTION -- requirements
Module: pacman_motion

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- START_X, 9'd112, spawn/respawn center x.
- START_Y, 9'd188, spawn/respawn center y.
- X_MIN, 9'd7, leftmost legal center x.
- X_MAX, 9'd216, rightmost legal center x.
- TILE_CENTER, 3'd4, low 3 bits of x/y at a tile center.
- SPEED_DIV, 2, frame_ticks per one-pixel step; legal range 1..15.
- ANIM_DIV, 4, moving steps per animation_cycle advance; legal range 1..15.
- RESPAWN_FRAMES, 120, frame_ticks spent dead; legal range 1..255.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- frame_tick, in, 1, one-cycle pulse per video frame.
- dir_req, in, 2, requested direction: 00 right, 01 up, 10 down, 11 left.
- dir_req_valid, in, 1, dir_req qualifier.
- blocked, in, 4, bit d set means direction d is walled from the current xloc/yloc; combinational from the maze.
- kill, in, 1, ghost-collision pulse.
- xloc, out, 9, pacman center x.
- yloc, out, 9, pacman center y.
- pacman_dir, out, 2, facing direction, same encoding as dir_req.
- pacman_alive, out, 1, 1 alive, 0 dead.
- animation_cycle, out, 2, mouth frame index.
- moving, out, 1, last step attempt succeeded.
REQ-003 All outputs SHALL be registered on clk; one clock domain only.

Function
REQ-004 The FSM SHALL have exactly two states, RUN and DEAD.
REQ-005 On dir_req_valid, dir_req SHALL be latched into pend_dir and pend_valid set. A newer request overwrites an older one.
REQ-006 A latched request SHALL take effect no earlier than the first frame_tick after the latching edge.
REQ-007 In RUN, on a step tick, a pending direction exactly opposite pacman_dir SHALL be applied immediately, at any position.
REQ-008 Any other pending direction SHALL be applied only when xloc[2:0]==TILE_CENTER and yloc[2:0]==TILE_CENTER and blocked[pend_dir]==0.
- Applying a pending direction sets pacman_dir and clears pend_valid.
- A pending direction that cannot be applied is retained.
REQ-009 A step tick SHALL be the frame_tick on which frame_cnt==SPEED_DIV-1.
- frame_cnt then returns to 0.
- frame_cnt otherwise increments by 1 per frame_tick.
REQ-010 On a step tick, pacman SHALL be stopped if it is at a tile center and blocked[pacman_dir]==1.
- Stopped: position held, moving<=0.
- Otherwise: xloc/yloc move one pixel in pacman_dir, moving<=1.
- Up decrements y; down increments y.
REQ-011 animation_cycle SHALL advance only on step ticks with moving set.
- It advances by 1 mod 4 after every ANIM_DIV such steps.
- It holds its value while stopped.
REQ-012 kill in RUN SHALL, at the next edge, set pacman_alive<=0, moving<=0, animation_cycle<=0, clear the death counter, and enter DEAD.
- kill takes priority over a coincident frame_tick; no step occurs on that edge.
REQ-013 In DEAD, kill and dir_req_valid SHALL be ignored, and position and pacman_dir SHALL hold.
REQ-014 In DEAD, each frame_tick SHALL increment the death counter.
REQ-015 On the frame_tick where the death counter reaches RESPAWN_FRAMES, the block SHALL enter RUN with:
- xloc=START_X, yloc=START_Y;
- pacman_dir=00, pacman_alive=1;
- pend_valid=0, frame_cnt=0.
REQ-016 Without wrap, x SHALL never leave [X_MIN, X_MAX]: a step that would exit the range stops the block with moving=0.

Reset
REQ-017 While rst is sampled high, the block SHALL load the following at each edge:
- xloc=START_X, yloc=START_Y;
- pacman_dir=00, pacman_alive=1;
- animation_cycle=0, moving=0;
- pend_valid=0, pend_dir=00;
- all counters 0; state RUN.
REQ-018 rst SHALL override every other input, including mid-DEAD and mid-step.

Configuration
REQ-019 Macro PACMAN_TUNNEL_WRAP_EN defined: a left step from xloc==X_MIN SHALL load X_MAX, and a right step from xloc==X_MAX SHALL load X_MIN. moving=1 in both cases.
REQ-020 Macro PACMAN_TUNNEL_WRAP_EN undefined: REQ-016 clamping SHALL apply.

Verification
REQ-021 Reset, then 2 frame_ticks with blocked=0 -> xloc=113, yloc=188, pacman_dir=00, moving=1.
REQ-022 Request up (01) at xloc=110, then step to xloc=116 with blocked=0 -> pacman_dir turns 01 on the step from 116; y decrements from then on.
REQ-023 Moving right, request left (11) mid-tile -> next step tick gives pacman_dir=11 and xloc decreases by 1.
REQ-024 At a tile center with blocked[0]=1, moving right -> xloc held, moving=0, animation_cycle frozen.
REQ-025 kill asserted coincident with frame_tick -> pacman_alive=0 and no position change.
- 119 further frame_ticks: still dead.
- 120th frame_tick: xloc=112, yloc=188, pacman_alive=1.
REQ-026 With PACMAN_TUNNEL_WRAP_EN, xloc=7 moving left, step tick -> xloc=216. Without the macro -> xloc=7, moving=0.
